// File: rtl/int_ctrl_if.sv
// Control-unit side of the interrupt controller: IRQ lines, enable-register
// write port, instruction-boundary/return strobes and the request outputs.
interface int_ctrl_if;
  // STEP marks an instruction boundary. interrupt is a one-cycle request that
  // is never held or retried. ret closes the current service period.
  logic [3:0] IRQ;
  logic       Wie;
  logic [4:0] DATAin;
  logic       STEP;
  logic       ret;
  logic       interrupt;
  logic [7:0] VECTOR;
  logic [7:0] STATUS;
  logic [1:0] dbg_state;

  modport master (
    output IRQ, Wie, DATAin, STEP, ret,
    input  interrupt, VECTOR, STATUS, dbg_state
  );

  modport slave (
    input  IRQ, Wie, DATAin, STEP, ret,
    output interrupt, VECTOR, STATUS, dbg_state
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-line priority interrupt controller with edge-detected pending bits.
// Define INT_SYNC_EN to use a two-flop synchronizer on each IRQ line.
module int_ctrl (
  input  logic      CLK,
  input  logic      RSTn,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       gie_q, gie_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] id_q, id_d;
  logic [3:0] samp_q;
  logic [3:0] prev_q;
  logic [3:0] edge_det;
  logic [3:0] cand;
  logic [1:0] sel;

`ifdef INT_SYNC_EN
  logic [3:0] sync1_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= 4'h0;
      samp_q  <= 4'h0;
    end else begin
      sync1_q <= bus.IRQ;
      samp_q  <= sync1_q;
    end
  end
`else
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      samp_q <= 4'h0;
    end else begin
      samp_q <= bus.IRQ;
    end
  end
`endif

  // prev_q starts at 0, so a line already high at reset release still yields an edge
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev_q <= 4'h0;
    end else begin
      prev_q <= samp_q;
    end
  end

  assign edge_det = samp_q & ~prev_q;
  assign cand     = pend_q & mask_q;

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) sel = 2'(i);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      gie_q   <= 1'b0;
      mask_q  <= 4'h0;
      pend_q  <= 4'h0;
      id_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      gie_q   <= gie_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    gie_d   = gie_q;
    mask_d  = mask_q;
    pend_d  = pend_q | edge_det;
    case (state_q)
      IDLE: begin
        if (gie_q && (|cand) && bus.STEP) begin
          state_d = REQ;
          id_d    = sel;
          // OR-ing the new edges after the clear lets a fresh edge on sel survive
          pend_d  = (pend_q & ~(4'b0001 << sel)) | edge_det;
        end
      end
      REQ:     state_d = SERVICE;
      SERVICE: if (bus.ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.Wie) begin
      gie_d  = bus.DATAin[4];
      mask_d = bus.DATAin[3:0];
    end
  end

  assign bus.interrupt = (state_q == REQ);
  assign bus.VECTOR    = (state_q == IDLE) ? 8'h00 : (8'hF0 + {4'h0, id_q, 2'b00});
  assign bus.STATUS    = {gie_q, (state_q != IDLE), id_q, pend_q};
  assign bus.dbg_state = state_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RSTn  input  1  asynchronous active-low reset.
REQ-004 IRQ  input  4  external interrupt lines, asynchronous, rising-edge sensitive; IRQ[0] has the highest priority.
REQ-005 Wie  input  1  write strobe for the enable register.
REQ-006 DATAin  input  5  enable-register write data: bit 4 is GIE (global enable), bits 3:0 are MASK (per line, 1 = enabled).
REQ-007 STEP  input  1  instruction boundary from the control unit; high in a cycle where the current instruction completes.
REQ-008 ret  input  1  return-from-interrupt strobe from the control unit.
REQ-009 interrupt  output  1  one-cycle interrupt request to the control unit.
REQ-010 VECTOR  output  8  ISR entry address.
REQ-011 STATUS  output  8  {GIE, INSERVICE, ID[1:0], PENDING[3:0]}.

Function
REQ-012 Each IRQ line SHALL pass through an input sampling stage, then a rising-edge detector (registered previous value); a detected edge SHALL set PENDING[i].
- Sampling stage depth is set by INT_SYNC_EN (REQ-028).
REQ-013 The FSM SHALL have states IDLE, REQ and SERVICE, held in registers.
REQ-014 Candidate set = PENDING & MASK; the selected line = lowest index in the candidate set.
REQ-015 IDLE -> REQ on a rising edge where all of these hold in the preceding cycle: GIE=1, candidate set non-zero, STEP=1.
- Otherwise the FSM stays in IDLE.
REQ-016 On the IDLE->REQ edge:
- ID latches the selected index.
- PENDING[ID] clears.
REQ-017 interrupt SHALL equal 1 exactly while state=REQ, i.e. for one cycle per accepted request.
REQ-018 REQ -> SERVICE unconditionally on the next edge.
REQ-019 SERVICE -> IDLE on the edge after a cycle with ret=1.
- ret in IDLE or REQ SHALL be ignored.
- No nesting: no new request is taken in SERVICE.
REQ-020 VECTOR SHALL be 8'hF0 + 4*ID in REQ and SERVICE, and 8'h00 in IDLE.
REQ-021 INSERVICE SHALL be 1 in REQ and SERVICE.
REQ-022 Wie=1 SHALL load GIE and MASK from DATAin on that edge.
- The new values affect the acceptance decision from the following cycle.
- An ID already latched is not affected.
REQ-023 If a new edge on line i is detected in the same cycle PENDING[i] is cleared by acceptance, set SHALL win and PENDING[i] remains 1.
REQ-024 Edges on masked lines, or arriving while GIE=0, SHALL still set PENDING; they are serviced once enabled.
- A second edge on an already-pending line is not counted.
REQ-025 Candidate-set width SHALL be 4 bits and ID 2 bits; VECTOR arithmetic SHALL not overflow (maximum 8'hFC).

Reset
REQ-026 While RSTn=0, the block SHALL force:
- State IDLE; interrupt=0, VECTOR=8'h00, STATUS=8'h00.
- GIE=0, MASK=4'h0, PENDING=4'h0, ID=2'b00.
- All sampling and edge registers to 0.
REQ-027 Reset asserted mid-operation (REQ or SERVICE) SHALL abandon the request immediately and discard all pending edges.
- After release, a line already high SHALL produce a pending edge.

Configuration
REQ-028 Macro INT_SYNC_EN SHALL select the sampling stage:
- Defined: two-flop synchronizer per line; an IRQ rising before edge k sets PENDING after edge k+2.
- Undefined: single sampling register; an IRQ rising before edge k sets PENDING after edge k+1.
- All other behaviour is identical in both builds.

Verification
REQ-029 Reset, Wie=1 with DATAin=5'h11, STEP=1, pulse IRQ[0] -> PENDING[0]=1 at the latency given in REQ-028; interrupt high for exactly 1 cycle; VECTOR=8'hF0; STATUS=8'hC0 in SERVICE.
REQ-030 MASK=4'hF, GIE=1, IRQ[3] and IRQ[1] rise together -> ID=1, VECTOR=8'hF4, PENDING=4'h8; after ret, a second request with VECTOR=8'hFC.
REQ-031 GIE=0, IRQ[2] edge -> no interrupt, PENDING=4'h4; then write DATAin=5'h14 -> request on the next STEP cycle with VECTOR=8'hF8.
REQ-032 In SERVICE, IRQ[0] edge -> no interrupt until ret=1; IDLE is entered, then a new request with VECTOR=8'hF0.
REQ-033 STEP=0 with a pending enabled line -> interrupt stays 0; it is asserted one cycle after STEP first goes 1.
REQ-034 RSTn pulled low during SERVICE -> all outputs 0 asynchronously, and no interrupt after release until a new edge.
